// File: rtl/fpr_pkg.sv
// Shared types and helpers for the FP register-file write-back path.
// Doubles occupy an even/odd register pair: low word in the even register, high word in the odd one.
package fpr_pkg;

  localparam int FPR_ADDR_W = 5;
  localparam int FPR_DATA_W = 32;
  localparam int FPR_NUM    = 32;

  typedef struct packed {
    logic [FPR_ADDR_W-1:0] rd;
    logic                  dbl;
    logic [FPR_DATA_W-1:0] lo;
    logic [FPR_DATA_W-1:0] hi;
  } fpr_wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } fpr_wb_state_t;

  function automatic logic [FPR_ADDR_W-1:0] fpr_lo_idx(input logic [FPR_ADDR_W-1:0] rd);
    return {rd[FPR_ADDR_W-1:1], 1'b0};
  endfunction

  function automatic logic [FPR_ADDR_W-1:0] fpr_hi_idx(input logic [FPR_ADDR_W-1:0] rd);
    return {rd[FPR_ADDR_W-1:1], 1'b1};
  endfunction

  function automatic logic [FPR_NUM-1:0] fpr_onehot(input logic [FPR_ADDR_W-1:0] idx);
    return FPR_NUM'(1) << idx;
  endfunction

  // Registers a buffered result will eventually write (both halves of the pair for a double).
  function automatic logic [FPR_NUM-1:0] fpr_target_mask(input logic [FPR_ADDR_W-1:0] rd,
                                                         input logic                  dbl);
    if (dbl) begin
      return fpr_onehot(fpr_lo_idx(rd)) | fpr_onehot(fpr_hi_idx(rd));
    end
    return fpr_onehot(rd);
  endfunction

endpackage

// File: rtl/fpr_wb_fifo.sv
// Small synchronous result FIFO; exposes the head plus per-entry destination info so the
// controller can build its pending-write mask without waiting for entries to drain.
module fpr_wb_fifo
  import fpr_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  fpr_wb_entry_t         push_data,
  input  logic                  pop,
  output fpr_wb_entry_t         head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [FPR_ADDR_W-1:0] entry_rd  [DEPTH],
  output logic [DEPTH-1:0]      entry_dbl
);

  fpr_wb_entry_t    mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  // A full FIFO refuses a push even when the head leaves on the same edge.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_rd[gi]    = mem_reg[gi].rd;
      assign entry_dbl[gi]   = mem_reg[gi].dbl;
    end
  endgenerate

endmodule

// File: rtl/fpr_wb_ctrl.sv
// FP register-file write-back producer: buffers FP unit results and issues one registered
// write per cycle, splitting doubles into lo/hi writes, and publishes pending targets.
module fpr_wb_ctrl
  import fpr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FPR_DATA_W,
  parameter int ADDR_W = FPR_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [ADDR_W-1:0]  res_rd,
  input  logic               res_dbl,
  input  logic [DATA_W-1:0]  res_lo,
  input  logic [DATA_W-1:0]  res_hi,
  input  logic               hold,
  output logic               regWr,
  output logic [ADDR_W-1:0]  Rw,
  output logic [DATA_W-1:0]  busW,
  output logic [FPR_NUM-1:0] pend_mask,
  output logic               empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fpr_wb_entry_t          push_data;
  fpr_wb_entry_t          head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [DEPTH-1:0]       entry_valid;
  logic [FPR_ADDR_W-1:0]  entry_rd [DEPTH];
  logic [DEPTH-1:0]       entry_dbl;
  logic [FPR_NUM-1:0]     entry_mask [DEPTH];

  fpr_wb_state_t          state_reg, state_next;
  logic                   regwr_reg, regwr_next;
  logic [ADDR_W-1:0]      rw_reg, rw_next;
  logic [DATA_W-1:0]      busw_reg, busw_next;

  assign push_data = '{rd: res_rd, dbl: res_dbl, lo: res_lo, hi: res_hi};
  assign res_ready = reset && !fifo_full;

  fpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (res_valid && res_ready),
    .push_data   (push_data),
    .pop         (pop),
    .head        (head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd),
    .entry_dbl   (entry_dbl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      regwr_reg <= 1'b0;
      rw_reg    <= '0;
      busw_reg  <= '0;
    end else begin
      state_reg <= state_next;
      regwr_reg <= regwr_next;
      rw_reg    <= rw_next;
      busw_reg  <= busw_next;
    end
  end

  // A hold freezes everything except regWr, which drops for the cycle.
  always_comb begin
    state_next = state_reg;
    regwr_next = 1'b0;
    rw_next    = rw_reg;
    busw_next  = busw_reg;
    pop        = 1'b0;
    if (!hold) begin
      case (state_reg)
        IDLE, WR_LO: begin
          if (!fifo_empty) begin
            rw_next    = head.dbl ? fpr_lo_idx(head.rd) : head.rd;
            busw_next  = head.lo;
            regwr_next = 1'b1;
            pop        = !head.dbl;
            state_next = head.dbl ? WR_HI : WR_LO;
          end else begin
            state_next = IDLE;
          end
        end
        WR_HI: begin
          rw_next    = fpr_hi_idx(head.rd);
          busw_next  = head.hi;
          regwr_next = 1'b1;
          pop        = 1'b1;
          state_next = WR_LO;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
      assign entry_mask[gi] = entry_valid[gi] ? fpr_target_mask(entry_rd[gi], entry_dbl[gi])
                                              : '0;
    end
  endgenerate

  // A double's head entry stays in the FIFO until its hi write issues, so both bits stay set.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask = pend_mask | entry_mask[i];
    end
    if (regwr_reg)          pend_mask = pend_mask | fpr_onehot(rw_reg);
    if (state_reg == WR_HI) pend_mask = pend_mask | fpr_onehot(fpr_hi_idx(head.rd));
  end

  assign regWr = regwr_reg;
  assign Rw    = rw_reg;
  assign busW  = busw_reg;
  assign empty = (fifo_count == '0) && !regwr_reg && (state_reg != WR_HI);

endmodule

// File: tb/tb_fpr_wb_ctrl.sv
// Bench for fpr_wb_ctrl: directed scenarios plus a randomized run against a queue-based
// model of accepted results and the writes each one still owes the register file.
module tb_fpr_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_rd;
  logic        res_dbl;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        hold;
  logic        regWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [31:0] pend_mask;
  logic        empty;

  fpr_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rd    (res_rd),
    .res_dbl   (res_dbl),
    .res_lo    (res_lo),
    .res_hi    (res_hi),
    .hold      (hold),
    .regWr     (regWr),
    .Rw        (Rw),
    .busW      (busW),
    .pend_mask (pend_mask),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    bit          dbl;
    logic [31:0] lo;
    logic [31:0] hi;
    int          done;
  } res_t;

  res_t        mq[$];
  bit          m_wr;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic model_clear();
    mq.delete();
    m_wr  = 1'b0;
    m_rw  = '0;
    m_bus = '0;
  endtask

  // One clock edge: the oldest owed write goes out unless held; new result joins if room.
  task automatic model_edge();
    bit   acc;
    res_t e;
    if (!reset) begin
      model_clear();
      return;
    end
    acc  = res_valid && (mq.size() < DEPTH);
    m_wr = 1'b0;
    if (!hold && mq.size() > 0) begin
      e    = mq[0];
      m_wr = 1'b1;
      if (!e.dbl) begin
        m_rw  = e.rd;
        m_bus = e.lo;
        void'(mq.pop_front());
      end else if (e.done == 0) begin
        m_rw  = {e.rd[4:1], 1'b0};
        m_bus = e.lo;
        mq[0].done = 1;
      end else begin
        m_rw  = {e.rd[4:1], 1'b1};
        m_bus = e.hi;
        void'(mq.pop_front());
      end
    end
    if (acc) begin
      e = '{rd: res_rd, dbl: res_dbl, lo: res_lo, hi: res_dbl ? res_hi : 32'h0, done: 0};
      mq.push_back(e);
    end
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) begin
      if (mq[i].dbl) m = m | (32'h1 << {mq[i].rd[4:1], 1'b0}) | (32'h1 << {mq[i].rd[4:1], 1'b1});
      else           m = m | (32'h1 << mq[i].rd);
    end
    if (m_wr) m = m | (32'h1 << m_rw);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic dbl, input logic [31:0] lo,
                       input logic [31:0] hi);
    res_valid = 1'b1;
    res_rd    = rd;
    res_dbl   = dbl;
    res_lo    = lo;
    res_hi    = hi;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_valid = 0; res_rd = 0; res_dbl = 0; res_lo = 0; res_hi = 0; hold = 0;
    #1 reset = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (regWr !== 1'b0) begin n_bad++; $display("FAIL reset_regwr: got %0b want 0", regWr); end
    n_cmp++; if (Rw !== 5'd0) begin n_bad++; $display("FAIL reset_rw: got %0d want 0", Rw); end
    n_cmp++; if (busW !== 32'h0) begin n_bad++; $display("FAIL reset_busw: got %h want 0", busW); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b want 0", res_ready); end
    step();
    step();
    reset = 1'b1;
    #1;
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %0b want 1", res_ready); end
    $display("reset: done");
  endtask

  task automatic test_single();
    offer(5'd5, 1'b0, 32'h3F800000, 32'h0);
    step();
    res_valid = 1'b0;
    n_cmp++; if (pend_mask !== 32'h20 || regWr !== 1'b0) begin n_bad++; $display("FAIL single_pend: pend=%h wr=%0b want 20/0", pend_mask, regWr); end
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'h3F800000) begin n_bad++; $display("FAIL single_write: wr=%0b rw=%0d bus=%h want 1/5/3f800000", regWr, Rw, busW); end
    n_cmp++; if (pend_mask !== 32'h20) begin n_bad++; $display("FAIL single_pend_wr: got %h want 20", pend_mask); end
    step();
    n_cmp++; if (regWr !== 1'b0 || pend_mask !== 32'h0 || empty !== 1'b1) begin n_bad++; $display("FAIL single_done: wr=%0b pend=%h empty=%0b want 0/0/1", regWr, pend_mask, empty); end
    $display("single: rd=5 written");
  endtask

  task automatic test_double();
    offer(5'd7, 1'b1, 32'h11111111, 32'h22222222);
    step();
    res_valid = 1'b0;
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd6 || busW !== 32'h11111111) begin n_bad++; $display("FAIL double_lo: wr=%0b rw=%0d bus=%h want 1/6/11111111", regWr, Rw, busW); end
    n_cmp++; if (pend_mask !== 32'hC0) begin n_bad++; $display("FAIL double_pend_lo: got %h want c0", pend_mask); end
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd7 || busW !== 32'h22222222) begin n_bad++; $display("FAIL double_hi: wr=%0b rw=%0d bus=%h want 1/7/22222222", regWr, Rw, busW); end
    n_cmp++; if (pend_mask !== 32'h80) begin n_bad++; $display("FAIL double_pend_hi: got %h want 80", pend_mask); end
    step();
    n_cmp++; if (regWr !== 1'b0 || pend_mask !== 32'h0) begin n_bad++; $display("FAIL double_done: wr=%0b pend=%h want 0/0", regWr, pend_mask); end
    $display("double: rd=7 written as 6,7");
  endtask

  task automatic test_fill();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(5'(i), 1'b0, 32'hA0 + 32'(i), 32'h0);
      step();
    end
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %0b want 0", res_ready); end
    offer(5'd20, 1'b0, 32'hDEAD, 32'h0);
    step();
    step();
    res_valid = 1'b0;
    n_cmp++; if (res_ready !== 1'b0 || pend_mask !== 32'h1E) begin n_bad++; $display("FAIL fill_held: ready=%0b pend=%h want 0/1e", res_ready, pend_mask); end
    hold = 1'b0;
    step();
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_after_pop: got %0b want 1", res_ready); end
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) step();
      n_cmp++; if (regWr !== 1'b1 || Rw !== 5'(i) || busW !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL fill_write%0d: wr=%0b rw=%0d bus=%h", i, regWr, Rw, busW); end
    end
    step();
    n_cmp++; if (regWr !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL fill_drained: wr=%0b empty=%0b want 0/1", regWr, empty); end
    $display("fill: 4 writes in order, 5th refused");
  endtask

  task automatic test_hold_double();
    logic [31:0] lo = $urandom;
    logic [31:0] hi = $urandom;
    offer(5'd10, 1'b1, lo, hi);
    step();
    res_valid = 1'b0;
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd10 || busW !== lo) begin n_bad++; $display("FAIL hold_lo: wr=%0b rw=%0d bus=%h want 1/10/%h", regWr, Rw, busW, lo); end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (regWr !== 1'b0 || pend_mask[11] !== 1'b1 || Rw !== 5'd10) begin n_bad++; $display("FAIL hold_cycle%0d: wr=%0b pend11=%0b rw=%0d", i, regWr, pend_mask[11], Rw); end
    end
    hold = 1'b0;
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd11 || busW !== hi) begin n_bad++; $display("FAIL hold_hi: wr=%0b rw=%0d bus=%h want 1/11/%h", regWr, Rw, busW, hi); end
    step();
    n_cmp++; if (regWr !== 1'b0 || pend_mask !== 32'h0) begin n_bad++; $display("FAIL hold_done: wr=%0b pend=%h", regWr, pend_mask); end
    $display("hold_double: hi write resumed after hold");
  endtask

  task automatic test_async_reset();
    offer(5'd12, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    step();
    res_valid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (regWr !== 1'b0 || pend_mask !== 32'h0 || empty !== 1'b1) begin n_bad++; $display("FAIL areset_now: wr=%0b pend=%h empty=%0b want 0/0/1", regWr, pend_mask, empty); end
    step();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %0b want 1", res_ready); end
    step();
    n_cmp++; if (regWr !== 1'b0 || pend_mask !== 32'h0) begin n_bad++; $display("FAIL areset_stale: wr=%0b pend=%h want 0/0", regWr, pend_mask); end
    $display("async_reset: hi write dropped");
  endtask

  task automatic test_back_to_back();
    offer(5'd2, 1'b0, 32'hAAAA0002, 32'h0);
    step();
    offer(5'd8, 1'b1, 32'hBBBB0008, 32'hCCCC0009);
    step();
    res_valid = 1'b0;
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd2 || busW !== 32'hAAAA0002) begin n_bad++; $display("FAIL b2b_w0: wr=%0b rw=%0d bus=%h", regWr, Rw, busW); end
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd8 || busW !== 32'hBBBB0008) begin n_bad++; $display("FAIL b2b_w1: wr=%0b rw=%0d bus=%h", regWr, Rw, busW); end
    step();
    n_cmp++; if (regWr !== 1'b1 || Rw !== 5'd9 || busW !== 32'hCCCC0009) begin n_bad++; $display("FAIL b2b_w2: wr=%0b rw=%0d bus=%h", regWr, Rw, busW); end
    step();
    n_cmp++; if (regWr !== 1'b0) begin n_bad++; $display("FAIL b2b_end: wr=%0b want 0", regWr); end
    $display("back_to_back: writes 2,8,9");
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 560) begin
        res_valid = ($urandom_range(0, 9) < 6);
        hold      = ($urandom_range(0, 3) == 0);
      end else begin
        res_valid = 1'b0;
        hold      = 1'b0;
      end
      res_rd  = 5'($urandom);
      res_dbl = $urandom_range(0, 1) == 1;
      res_lo  = $urandom;
      res_hi  = $urandom;
      step();
      n_cmp++; if (regWr !== m_wr) begin n_bad++; $display("FAIL rand_regwr c%0d: got %0b want %0b", cyc, regWr, m_wr); end
      n_cmp++; if (Rw !== m_rw) begin n_bad++; $display("FAIL rand_rw c%0d: got %0d want %0d", cyc, Rw, m_rw); end
      n_cmp++; if (busW !== m_bus) begin n_bad++; $display("FAIL rand_busw c%0d: got %h want %h", cyc, busW, m_bus); end
      n_cmp++; if (pend_mask !== exp_mask()) begin n_bad++; $display("FAIL rand_pend c%0d: got %h want %h", cyc, pend_mask, exp_mask()); end
      n_cmp++; if (empty !== (mq.size() == 0 && !m_wr)) begin n_bad++; $display("FAIL rand_empty c%0d: got %0b want %0b", cyc, empty, (mq.size() == 0 && !m_wr)); end
      n_cmp++; if (res_ready !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rand_ready c%0d: got %0b want %0b", cyc, res_ready, (mq.size() < DEPTH)); end
      if (m_wr) $display("random c%0d: write rw=%0d data=%h", cyc, m_rw, m_bus);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_fill();
    test_hold_double();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
